prog_timer_bank: RTL and testbench

- Parametrised bank of independent programmable down-counting timers; successor to the fixed 256 Hz divider/stopwatch block.
- A shared prescaler and divider chain derive eight tick rates from the system clock.
- Each channel selects one rate and counts down from a software reload value.
- Each channel supports auto-reload or one-shot mode and raises a sticky underflow flag plus a one-cycle pulse for the interrupt controller.

---
 rtl/prog_timer_bank.sv | 113 +++++++++++
 tb/tb_prog_timer_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer_bank.sv
// Bank of independent programmable down-counting timers sharing one prescaler
// and a binary divider chain that provides eight power-of-two tick rates.
module prog_timer_bank #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 128
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [3*CHANNELS-1:0]     src_sel,
    input  logic [WIDTH*CHANNELS-1:0] reload_data,
    input  logic [CHANNELS-1:0]       write_reload,
    input  logic [CHANNELS-1:0]       restart,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       one_shot,
    input  logic [CHANNELS-1:0]       clear_flag,
    output logic [WIDTH*CHANNELS-1:0] count,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       underflow_pulse,
    output logic [CHANNELS-1:0]       underflow_flag
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] prescaler_reg;
    logic [6:0]      divider_reg;
    logic            base_tick;
    logic [7:0]      tap;

    assign base_tick = (prescaler_reg == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_reg <= '0;
            divider_reg   <= '0;
        end else begin
            prescaler_reg <= base_tick ? '0 : prescaler_reg + PS_W'(1);
            if (base_tick) begin
                divider_reg <= divider_reg + 7'd1;
            end
        end
    end

    // tap k fires on the base tick that carries out of divider bit k-1
    assign tap[0] = base_tick;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_tap
            assign tap[gi] = base_tick & (&divider_reg[gi-1:0]);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] count_reg, count_next;
            logic [WIDTH-1:0] reload_reg, reload_next;
            logic             running_reg, running_next;
            logic             pulse_reg, pulse_next;
            logic             flag_reg, flag_next;
            logic [2:0]       sel;
            logic             src_tick;

            assign sel      = src_sel[3*gi +: 3];
            assign src_tick = tap[sel];

            always_comb begin
                reload_next  = write_reload[gi] ? reload_data[WIDTH*gi +: WIDTH] : reload_reg;
                count_next   = count_reg;
                running_next = running_reg;
                pulse_next   = 1'b0;
                flag_next    = clear_flag[gi] ? 1'b0 : flag_reg;
                // restart swallows any coincident tick, so it can never underflow
                if (restart[gi]) begin
                    count_next   = reload_next;
                    running_next = 1'b1;
                end else if (running_reg && enable[gi] && src_tick) begin
                    if (count_reg != '0) begin
                        count_next = count_reg - WIDTH'(1);
                    end else begin
                        pulse_next = 1'b1;
                        flag_next  = 1'b1;
                        if (one_shot[gi]) begin
                            running_next = 1'b0;
                        end else begin
                            count_next = reload_reg;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg   <= '0;
                    reload_reg  <= '0;
                    running_reg <= 1'b0;
                    pulse_reg   <= 1'b0;
                    flag_reg    <= 1'b0;
                end else begin
                    count_reg   <= count_next;
                    reload_reg  <= reload_next;
                    running_reg <= running_next;
                    pulse_reg   <= pulse_next;
                    flag_reg    <= flag_next;
                end
            end

            assign count[WIDTH*gi +: WIDTH] = count_reg;
            assign running[gi]              = running_reg;
            assign underflow_pulse[gi]      = pulse_reg;
            assign underflow_flag[gi]       = flag_reg;
        end
    endgenerate

endmodule

// File: tb/tb_prog_timer_bank.sv
// Directed bench for prog_timer_bank with PRESCALE=4: tap k acts on clk edges
// that are multiples of 4*2^k counted from reset release.
module tb_prog_timer_bank;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 8;
    localparam int PRESCALE = 4;

    logic                      clk;
    logic                      reset_n;
    logic [3*CHANNELS-1:0]     src_sel;
    logic [WIDTH*CHANNELS-1:0] reload_data;
    logic [CHANNELS-1:0]       write_reload;
    logic [CHANNELS-1:0]       restart;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       one_shot;
    logic [CHANNELS-1:0]       clear_flag;
    logic [WIDTH*CHANNELS-1:0] count;
    logic [CHANNELS-1:0]       running;
    logic [CHANNELS-1:0]       underflow_pulse;
    logic [CHANNELS-1:0]       underflow_flag;

    int checks_reg;
    int failures_reg;
    int cyc;

    prog_timer_bank #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .src_sel         (src_sel),
        .reload_data     (reload_data),
        .write_reload    (write_reload),
        .restart         (restart),
        .enable          (enable),
        .one_shot        (one_shot),
        .clear_flag      (clear_flag),
        .count           (count),
        .running         (running),
        .underflow_pulse (underflow_pulse),
        .underflow_flag  (underflow_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_reg++;
        if (got !== exp) begin
            failures_reg++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end else begin
            $display("ok   %s cyc=%0d value=%0d", tag, cyc, got);
        end
    endtask

    // Advance to the negedge following posedge number 'target' after release
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic clear_inputs();
        src_sel      = '0;
        reload_data  = '0;
        write_reload = '0;
        restart      = '0;
        enable       = '0;
        one_shot     = '0;
        clear_flag   = '0;
    endtask

    initial begin
        checks_reg   = 0;
        failures_reg = 0;
        cyc          = 0;
        reset_n      = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);

        check_eq("rst_count",   32'(count),           32'd0);
        check_eq("rst_running", 32'(running),         32'd0);
        check_eq("rst_flag",    32'(underflow_flag),  32'd0);
        reset_n = 1'b1;
        cyc     = 0;

        // Auto-reload on channel 0, reload=3, tap0
        reload_data[7:0] = 8'd3;
        write_reload     = 2'b01;
        restart          = 2'b01;
        enable           = 2'b01;
        run_to(1);
        write_reload = '0;
        restart      = '0;
        check_eq("auto_start_cnt", 32'(count[7:0]), 32'd3);
        check_eq("auto_start_run", 32'(running),    32'd1);
        run_to(4);
        check_eq("auto_cnt_t4", 32'(count[7:0]), 32'd2);
        run_to(15);
        check_eq("auto_cnt_t15",   32'(count[7:0]),      32'd0);
        check_eq("auto_pulse_t15", 32'(underflow_pulse), 32'd0);
        run_to(16);
        check_eq("auto_pulse_t16", 32'(underflow_pulse), 32'd1);
        check_eq("auto_flag_t16",  32'(underflow_flag),  32'd1);
        check_eq("auto_cnt_t16",   32'(count[7:0]),      32'd3);
        run_to(17);
        check_eq("auto_pulse_t17", 32'(underflow_pulse), 32'd0);
        check_eq("auto_flag_t17",  32'(underflow_flag),  32'd1);
        run_to(32);
        check_eq("auto_pulse_t32", 32'(underflow_pulse), 32'd1);
        run_to(33);
        clear_flag = 2'b01;
        run_to(34);
        clear_flag = '0;
        check_eq("clear_flag", 32'(underflow_flag), 32'd0);

        // clear_flag coinciding with an underflow: set wins
        run_to(47);
        clear_flag = 2'b01;
        run_to(48);
        clear_flag = '0;
        check_eq("setwins_pulse", 32'(underflow_pulse), 32'd1);
        check_eq("setwins_flag",  32'(underflow_flag),  32'd1);

        // Restart + write_reload on a tick at count 0: new value, no underflow
        run_to(63);
        check_eq("prio_pre_cnt", 32'(count[7:0]), 32'd0);
        reload_data[7:0] = 8'd9;
        write_reload     = 2'b01;
        restart          = 2'b01;
        run_to(64);
        write_reload = '0;
        restart      = '0;
        check_eq("prio_cnt",   32'(count[7:0]),      32'd9);
        check_eq("prio_pulse", 32'(underflow_pulse), 32'd0);
        run_to(68);
        check_eq("prio_next_cnt", 32'(count[7:0]), 32'd8);

        // Enable freeze at count 5 for 40 clk
        run_to(80);
        check_eq("freeze_pre_cnt", 32'(count[7:0]), 32'd5);
        enable = '0;
        run_to(120);
        check_eq("freeze_cnt", 32'(count[7:0]), 32'd5);
        check_eq("freeze_run", 32'(running),    32'd1);
        enable = 2'b01;
        run_to(124);
        check_eq("resume_cnt", 32'(count[7:0]), 32'd4);

        // write_reload alone leaves the count untouched until the next reload
        reload_data[7:0] = 8'd20;
        write_reload     = 2'b01;
        run_to(125);
        write_reload = '0;
        check_eq("wr_only_cnt", 32'(count[7:0]), 32'd4);
        run_to(144);
        check_eq("wr_reload_cnt",   32'(count[7:0]),      32'd20);
        check_eq("wr_reload_pulse", 32'(underflow_pulse), 32'd1);

        // Asynchronous reset while count = 5
        run_to(204);
        check_eq("arst_pre_cnt", 32'(count[7:0]), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_count",   32'(count),           32'd0);
        check_eq("arst_running", 32'(running),         32'd0);
        check_eq("arst_flag",    32'(underflow_flag),  32'd0);
        check_eq("arst_pulse",   32'(underflow_pulse), 32'd0);
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;

        // One-shot on channel 0, reload=2, tap1 (acts every 8 clk)
        src_sel[2:0]     = 3'd1;
        reload_data[7:0] = 8'd2;
        write_reload     = 2'b01;
        restart          = 2'b01;
        enable           = 2'b01;
        one_shot         = 2'b01;
        run_to(1);
        write_reload = '0;
        restart      = '0;
        run_to(7);
        check_eq("os_cnt_t7", 32'(count[7:0]), 32'd2);
        run_to(8);
        check_eq("os_cnt_t8", 32'(count[7:0]), 32'd1);
        run_to(23);
        check_eq("os_pulse_t23", 32'(underflow_pulse), 32'd0);
        run_to(24);
        check_eq("os_pulse_t24", 32'(underflow_pulse), 32'd1);
        check_eq("os_run_t24",   32'(running),         32'd0);
        check_eq("os_cnt_t24",   32'(count[7:0]),      32'd0);
        check_eq("os_flag_t24",  32'(underflow_flag),  32'd1);
        run_to(48);
        check_eq("os_idle_cnt",   32'(count[7:0]),      32'd0);
        check_eq("os_idle_pulse", 32'(underflow_pulse), 32'd0);
        restart = 2'b01;
        run_to(49);
        restart = '0;
        check_eq("os_rearm_cnt", 32'(count[7:0]), 32'd2);
        check_eq("os_rearm_run", 32'(running),    32'd1);

        // Independence: ch0 tap0 reload 0, ch1 tap7 reload 1
        src_sel      = {3'd7, 3'd0};
        reload_data  = {8'd1, 8'd0};
        write_reload = 2'b11;
        restart      = 2'b11;
        enable       = 2'b11;
        one_shot     = 2'b00;
        run_to(50);
        write_reload = '0;
        restart      = '0;
        check_eq("ind_start_cnt", 32'(count), 32'h0100);
        run_to(52);
        check_eq("ind_pulse_t52", 32'(underflow_pulse), 32'd1);
        run_to(53);
        check_eq("ind_pulse_t53", 32'(underflow_pulse), 32'd0);
        run_to(56);
        check_eq("ind_pulse_t56", 32'(underflow_pulse), 32'd1);
        run_to(512);
        check_eq("ind_ch1_t512", 32'(count[15:8]), 32'd0);
        check_eq("ind_pulse_t512", 32'(underflow_pulse), 32'd1);
        run_to(1023);
        check_eq("ind_pulse_t1023", 32'(underflow_pulse), 32'd0);
        run_to(1024);
        check_eq("ind_pulse_t1024", 32'(underflow_pulse), 32'd3);
        check_eq("ind_cnt_t1024",   32'(count),           32'h0100);
        check_eq("ind_flag_t1024",  32'(underflow_flag),  32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks_reg, failures_reg);
        $finish;
    end

endmodule
